// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the
// unified-memory port arbiter.
package mips_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic [63:0] WORD_ALIGN_MASK = ~64'h3;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side
// signals of the shared memory port.
interface mem_port_arbiter_if
    import mips_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              stall_f;
    logic              stall_m;
    logic              err;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata, mem_ack,
        output i_rdata, i_ready,
        output d_rdata, d_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output stall_f, stall_m, err
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata, mem_ack,
        input  i_rdata, i_ready,
        input  d_rdata, d_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  stall_f, stall_m, err
    );

endinterface

// File: rtl/mem_watchdog.sv
// mem_watchdog: counts serve cycles without an ack and
// flags expiry on the cycle that would reach TIMEOUT.
module mem_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic f_clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    assign expired = enable && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge f_clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between
// the fetch (I) and memory-stage (D) ports of the pipeline.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_D_STREAK = 3,
    parameter int TIMEOUT      = 255
) (
    input logic               f_clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [ADDR_W-1:0] AMASK =
        WORD_ALIGN_MASK[ADDR_W-1:0];

    arb_state_t    state;
    logic [SW-1:0] d_streak;
    logic          i_elig;
    logic          d_elig;
    logic          grant_i;
    logic          grant_d;
    logic          wd_exp;

    // A port pulsing ready this cycle must not be re-granted.
    assign i_elig  = bus.i_req & ~bus.i_ready;
    assign d_elig  = bus.d_req & ~bus.d_ready;
    assign grant_i = (state == IDLE) && i_elig &&
                     (!d_elig ||
                      d_streak == SW'(MAX_D_STREAK));
    assign grant_d = (state == IDLE) && d_elig && !grant_i;

    assign bus.stall_f = bus.i_req & ~bus.i_ready;
    assign bus.stall_m = bus.d_req & ~bus.d_ready;

    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .f_clk   (f_clk),
        .rst     (rst),
        .clear   (grant_i | grant_d),
        .enable  ((state != IDLE) & ~bus.mem_ack),
        .expired (wd_exp)
    );

    always_ff @(posedge f_clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            d_streak      <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.i_rdata   <= '0;
            bus.d_rdata   <= '0;
            bus.i_ready   <= 1'b0;
            bus.d_ready   <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.i_ready <= 1'b0;
            bus.d_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_i) begin
                        state        <= SERVE_I;
                        d_streak     <= '0;
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= bus.i_addr & AMASK;
                    end else if (grant_d) begin
                        state         <= SERVE_D;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= bus.d_we;
                        bus.mem_addr  <= bus.d_addr & AMASK;
                        bus.mem_wdata <= bus.d_wdata;
                        if (d_streak != SW'(MAX_D_STREAK))
                            d_streak <= d_streak + 1'b1;
                    end
                end
                SERVE_I: begin
                    if (bus.mem_ack || wd_exp) begin
                        state       <= IDLE;
                        bus.mem_req <= 1'b0;
                        bus.i_ready <= 1'b1;
                        if (bus.mem_ack) begin
                            bus.i_rdata <= bus.mem_rdata;
                        end else begin
                            bus.i_rdata <= {DATA_W{1'b0}};
                            bus.err     <= 1'b1;
                        end
                    end
                end
                SERVE_D: begin
                    if (bus.mem_ack || wd_exp) begin
                        state       <= IDLE;
                        bus.mem_req <= 1'b0;
                        bus.d_ready <= 1'b1;
                        // Stores leave the last load data visible.
                        if (bus.mem_ack) begin
                            if (!bus.mem_we)
                                bus.d_rdata <= bus.mem_rdata;
                        end else begin
                            bus.d_rdata <= {DATA_W{1'b0}};
                            bus.err     <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench: I/D requesters, a memory
// responder with wait states and hangs, and a monitor.
module tb_mem_port_arbiter;
    import mips_pkg::*;

    localparam int TO   = 4;
    localparam int MAXS = 3;
    localparam int N_I  = 60;
    localparam int N_D  = 80;

    typedef struct {
        logic [31:0] rdata;
        bit          hang;
    } exp_t;

    logic f_clk = 1'b0;
    logic rst   = 1'b0;
    always #5 f_clk = ~f_clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32),
        .MAX_D_STREAK(MAXS), .TIMEOUT(TO)
    ) dut (
        .f_clk(f_clk), .rst(rst), .bus(bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    exp_t i_q[$];
    exp_t d_q[$];
    logic [31:0] dmodel [logic [31:0]];
    logic [31:0] rmem   [logic [31:0]];
    logic [31:0] d_last = 32'h0;

    bit resp_en   = 1'b1;
    bit force_ack = 1'b0;
    bit mon_en    = 1'b0;
    bit exp_err   = 1'b0;
    int cur_wait  = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h",
                      name, act, exp);
    endtask

    function automatic logic [31:0] init_word(
        input logic [31:0] a);
        return ((a & 32'hFFFF_FFFC) * 32'h9E37_79B1)
               ^ 32'h0BAD_F00D;
    endfunction

    // Word slots 15 of every 64-byte block never answer.
    function automatic bit is_hang(input logic [31:0] a);
        return a[5:2] == 4'hF;
    endfunction

    // Memory responder: random 0..3 wait states per access.
    initial begin : responder
        bit busy;
        int wcnt;
        busy = 1'b0;
        wcnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge f_clk); #1;
            bus.mem_ack   = force_ack;
            bus.mem_rdata = $urandom;
            if (!bus.mem_req || !resp_en) begin
                busy = 1'b0;
            end else if (!is_hang(bus.mem_addr)) begin
                if (!busy) begin
                    busy     = 1'b1;
                    wcnt     = $urandom_range(0, 3);
                    cur_wait = wcnt;
                end
                if (wcnt == 0) begin
                    bus.mem_ack = 1'b1;
                    busy        = 1'b0;
                    if (bus.mem_we)
                        rmem[bus.mem_addr] = bus.mem_wdata;
                    else if (rmem.exists(bus.mem_addr))
                        bus.mem_rdata = rmem[bus.mem_addr];
                    else
                        bus.mem_rdata = init_word(bus.mem_addr);
                end else begin
                    wcnt--;
                end
            end
        end
    end

    // Monitor: grant rule, stable bus, ready/data scoreboard.
    bit          p_i_elig = 0, p_d_elig = 0, p_mreq = 0;
    bit          p_d_we = 0, cur_i = 0;
    logic [31:0] p_i_addr = 0, p_d_addr = 0, p_d_wdata = 0;
    logic [31:0] p_maddr = 0, p_mwdata = 0;
    bit          p_mwe = 0;
    int          streak = 0, scnt = 0;

    always @(negedge f_clk) begin
        if (mon_en) begin
            bit   done, exp_i;
            exp_t e;
            check("stall_f", bus.stall_f,
                  bus.i_req & ~bus.i_ready);
            check("stall_m", bus.stall_m,
                  bus.d_req & ~bus.d_ready);
            done = p_mreq && !bus.mem_req;
            check("i_ready", bus.i_ready, done && cur_i);
            check("d_ready", bus.d_ready, done && !cur_i);
            if (done) begin
                if ((cur_i ? i_q.size() : d_q.size()) == 0) begin
                    n_total++;
                    $display("FAIL scoreboard: got completion, required none");
                end else begin
                    e = cur_i ? i_q.pop_front() : d_q.pop_front();
                    check(cur_i ? "i_rdata" : "d_rdata",
                          cur_i ? bus.i_rdata : bus.d_rdata,
                          e.rdata);
                    check("serve_len", scnt,
                          e.hang ? TO : cur_wait + 1);
                    if (e.hang) exp_err = 1'b1;
                    check("err", bus.err, exp_err);
                end
            end
            if (!p_mreq) begin
                check("grant", bus.mem_req, p_i_elig | p_d_elig);
                if (bus.mem_req) begin
                    exp_i = p_i_elig &&
                            (!p_d_elig || streak == MAXS);
                    check("grant_port", bus.mem_addr[12], exp_i);
                    cur_i = exp_i;
                    scnt  = 1;
                    if (exp_i) begin
                        check("i_maddr", bus.mem_addr,
                              p_i_addr & 32'hFFFF_FFFC);
                        check("i_mwe", bus.mem_we, 1'b0);
                        streak = 0;
                    end else begin
                        check("d_maddr", bus.mem_addr,
                              p_d_addr & 32'hFFFF_FFFC);
                        check("d_mwe", bus.mem_we, p_d_we);
                        if (p_d_we)
                            check("d_mwdata", bus.mem_wdata,
                                  p_d_wdata);
                        if (streak < MAXS) streak++;
                    end
                end
            end else if (bus.mem_req) begin
                scnt++;
                check("hold_addr", bus.mem_addr, p_maddr);
                check("hold_we", bus.mem_we, p_mwe);
                if (p_mwe)
                    check("hold_wdata", bus.mem_wdata, p_mwdata);
            end
            p_i_elig  = bus.i_req & ~bus.i_ready;
            p_d_elig  = bus.d_req & ~bus.d_ready;
            p_mreq    = bus.mem_req;
            p_i_addr  = bus.i_addr;
            p_d_addr  = bus.d_addr;
            p_d_we    = bus.d_we;
            p_d_wdata = bus.d_wdata;
            p_maddr   = bus.mem_addr;
            p_mwe     = bus.mem_we;
            p_mwdata  = bus.mem_wdata;
        end
    end

    task automatic wait_ready(input bit is_d);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(posedge f_clk); #1;
            got = is_d ? bus.d_ready : bus.i_ready;
        end
        if (!got) begin
            n_total++;
            $display("FAIL ready_wait port_d=%0d: got 0 required 1",
                     is_d);
        end
    endtask

    task automatic i_gen();
        exp_t        e;
        logic [31:0] a;
        for (int n = 0; n < N_I; n++) begin
            repeat ($urandom_range(0, 4)) begin
                @(posedge f_clk); #1;
            end
            a       = 32'h1000 | ($urandom & 32'h0FFF);
            e.hang  = is_hang(a);
            e.rdata = e.hang ? 32'h0 : init_word(a);
            i_q.push_back(e);
            bus.i_addr = a;
            bus.i_req  = 1'b1;
            wait_ready(1'b0);
            bus.i_req  = 1'b0;
        end
    endtask

    task automatic d_gen();
        exp_t        e;
        logic [31:0] a, wa, wd;
        bit          we;
        for (int n = 0; n < N_D; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge f_clk); #1;
            end
            we     = 1'($urandom_range(0, 1));
            a      = $urandom & 32'h0FFF;
            wd     = $urandom;
            wa     = a & 32'hFFFF_FFFC;
            e.hang = is_hang(a);
            if (e.hang) begin
                e.rdata = 32'h0;
                d_last  = 32'h0;
            end else if (we) begin
                dmodel[wa] = wd;
                e.rdata    = d_last;
            end else begin
                e.rdata = dmodel.exists(wa) ? dmodel[wa]
                                            : init_word(wa);
                d_last  = e.rdata;
            end
            d_q.push_back(e);
            bus.d_we    = we;
            bus.d_addr  = a;
            bus.d_wdata = wd;
            bus.d_req   = 1'b1;
            wait_ready(1'b1);
            bus.d_req   = 1'b0;
        end
    endtask

    initial begin
        bus.i_req   = 1'b0;
        bus.i_addr  = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        #1 rst = 1'b1;
        #20;
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_i_ready", bus.i_ready, 1'b0);
        check("rst_d_ready", bus.d_ready, 1'b0);
        check("rst_i_rdata", bus.i_rdata, 32'h0);
        check("rst_d_rdata", bus.d_rdata, 32'h0);
        check("rst_err", bus.err, 1'b0);
        @(posedge f_clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        fork
            i_gen();
            d_gen();
        join

        repeat (2) begin
            @(posedge f_clk); #1;
        end
        check("i_q_drained", i_q.size(), 0);
        check("d_q_drained", d_q.size(), 0);
        check("err_sticky", bus.err, exp_err);

        // Reset in the second SERVE_D cycle of a stalled load.
        mon_en      = 1'b0;
        resp_en     = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h40;
        bus.d_req   = 1'b1;
        @(posedge f_clk); #1;
        check("rst_t_serve1", bus.mem_req, 1'b1);
        @(posedge f_clk); #1;
        check("rst_t_serve2", bus.mem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_t_mem_req", bus.mem_req, 1'b0);
        check("rst_t_err", bus.err, 1'b0);
        bus.d_req = 1'b0;
        @(posedge f_clk); #1;
        rst       = 1'b0;
        force_ack = 1'b1;
        @(posedge f_clk); #1;
        force_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge f_clk);
            check("late_ack_d_ready", bus.d_ready, 1'b0);
            check("late_ack_i_ready", bus.i_ready, 1'b0);
            check("late_ack_mem_req", bus.mem_req, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
